// File: rtl/control_mc.sv
// Multi-channel MSDAP sequencer: Rj/coeff load addressing, interleaved data steering, per-channel zero-run sleep.
// Strobes are same-cycle combinational from state and in_valid; in_ready drops only in INIT and CLEARING.
module control_mc #(
  parameter int NUM_CH      = 2,
  parameter int RJ_DEPTH    = 16,
  parameter int COEFF_DEPTH = 512,
  parameter int ZERO_RUN    = 800,
  localparam int RJ_AW = (NUM_CH * RJ_DEPTH > 1) ? $clog2(NUM_CH * RJ_DEPTH) : 1,
  localparam int CF_AW = (NUM_CH * COEFF_DEPTH > 1) ? $clog2(NUM_CH * COEFF_DEPTH) : 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              soft_clear,
  input  logic              frame,
  input  logic              in_valid,
  input  logic              in_zero,
  output logic              in_ready,
  output logic              rj_wr_en,
  output logic [RJ_AW-1:0]  rj_addr,
  output logic              coeff_wr_en,
  output logic [CF_AW-1:0]  coeff_addr,
  output logic              data_wr_en,
  output logic [CH_W-1:0]   data_ch,
  output logic              mem_clear,
  output logic              data_clear,
  output logic              alu_en,
  output logic              out_mask,
  output logic [NUM_CH-1:0] ch_idle
);

  localparam int ZW = $clog2(ZERO_RUN + 1);
  localparam logic [RJ_AW-1:0] RJ_LAST = RJ_AW'(NUM_CH * RJ_DEPTH - 1);
  localparam logic [CF_AW-1:0] CF_LAST = CF_AW'(NUM_CH * COEFF_DEPTH - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [ZW-1:0]    Z_SAT   = ZW'(ZERO_RUN);

  typedef enum logic [3:0] {
    INIT, WAIT_RJ, READ_RJ, WAIT_COEFF, READ_COEFF,
    WAIT_DATA, WORKING, SLEEPING, CLEARING
  } state_t;

  state_t            state_q, state_d;
  logic [RJ_AW-1:0]  rj_addr_q, rj_addr_d;
  logic [CF_AW-1:0]  coeff_addr_q, coeff_addr_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [ZW-1:0]     zcnt_q [NUM_CH];
  logic [ZW-1:0]     zcnt_d [NUM_CH];

  logic              active;
  logic              data_acc;
  logic              all_idle;
  logic [CH_W-1:0]   cur_ch;
  logic [NUM_CH-1:0] idle_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      rj_addr_q    <= '0;
      coeff_addr_q <= '0;
      ch_idx_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) zcnt_q[c] <= '0;
    end else begin
      state_q      <= state_d;
      rj_addr_q    <= rj_addr_d;
      coeff_addr_q <= coeff_addr_d;
      ch_idx_q     <= ch_idx_d;
      for (int c = 0; c < NUM_CH; c++) zcnt_q[c] <= zcnt_d[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) idle_vec[c] = (zcnt_q[c] == Z_SAT);
  end

  assign all_idle = &idle_vec;
  // Outputs are silenced both in reset and in the cycle a restart is requested.
  assign active   = reset_n & ~start;
  assign cur_ch   = (frame && in_valid) ? '0 : ch_idx_q;

  always_comb begin
    state_d      = state_q;
    rj_addr_d    = rj_addr_q;
    coeff_addr_d = coeff_addr_q;
    ch_idx_d     = ch_idx_q;
    for (int c = 0; c < NUM_CH; c++) zcnt_d[c] = zcnt_q[c];
    data_acc     = 1'b0;
    in_ready     = 1'b0;
    rj_wr_en     = 1'b0;
    coeff_wr_en  = 1'b0;
    data_wr_en   = 1'b0;
    mem_clear    = 1'b0;
    data_clear   = 1'b0;
    alu_en       = 1'b0;
    out_mask     = 1'b0;
    rj_addr      = active ? rj_addr_q : '0;
    coeff_addr   = active ? coeff_addr_q : '0;
    data_ch      = active ? cur_ch : '0;
    ch_idle      = active ? idle_vec : '0;

    if (!active) begin
      state_d = INIT;
    end else begin
      unique case (state_q)
        INIT: begin
          mem_clear    = 1'b1;
          data_clear   = 1'b1;
          rj_addr_d    = '0;
          coeff_addr_d = '0;
          ch_idx_d     = '0;
          for (int c = 0; c < NUM_CH; c++) zcnt_d[c] = '0;
          state_d      = WAIT_RJ;
        end
        WAIT_RJ, READ_RJ: begin
          in_ready = 1'b1;
          if (in_valid && (frame || state_q == READ_RJ)) begin
            rj_wr_en = 1'b1;
            if (rj_addr_q == RJ_LAST) begin
              rj_addr_d = '0;
              state_d   = WAIT_COEFF;
            end else begin
              rj_addr_d = rj_addr_q + RJ_AW'(1);
              state_d   = READ_RJ;
            end
          end
        end
        WAIT_COEFF, READ_COEFF: begin
          in_ready = 1'b1;
          if (in_valid && (frame || state_q == READ_COEFF)) begin
            coeff_wr_en = 1'b1;
            if (coeff_addr_q == CF_LAST) begin
              coeff_addr_d = '0;
              state_d      = WAIT_DATA;
            end else begin
              coeff_addr_d = coeff_addr_q + CF_AW'(1);
              state_d      = READ_COEFF;
            end
          end
        end
        WAIT_DATA, WORKING, SLEEPING: begin
          in_ready = 1'b1;
          alu_en   = (state_q == WORKING);
          out_mask = (state_q == SLEEPING);
          if (soft_clear) begin
            state_d = CLEARING;
          end else begin
            if (in_valid && (frame || state_q != WAIT_DATA)) begin
              data_wr_en = 1'b1;
              data_acc   = 1'b1;
              ch_idx_d   = (cur_ch == CH_LAST) ? '0 : cur_ch + CH_W'(1);
              if (state_q == WAIT_DATA || (state_q == SLEEPING && !in_zero)) state_d = WORKING;
            end
            // A nonzero sample arriving alongside saturation outranks the sleep decision.
            if (state_q == WORKING && all_idle && !(data_acc && !in_zero)) state_d = SLEEPING;
          end
        end
        CLEARING: begin
          data_clear = 1'b1;
          ch_idx_d   = '0;
          for (int c = 0; c < NUM_CH; c++) zcnt_d[c] = '0;
          state_d    = WAIT_DATA;
        end
        default: state_d = INIT;
      endcase
    end

    if (data_acc) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cur_ch == CH_W'(c)) begin
          if (!in_zero)                zcnt_d[c] = '0;
          else if (zcnt_q[c] != Z_SAT) zcnt_d[c] = zcnt_q[c] + ZW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_control_mc.sv
// Scoreboard bench for control_mc: expected write strobes queued at drive time, popped by a negedge monitor.
module tb_control_mc;

  localparam int NCH = 2;
  localparam int ZR  = 4;
  localparam int NRJ = 32;
  localparam int NCF = 1024;

  logic clk, reset_n, start, soft_clear, frame, in_valid, in_zero;
  logic       in_ready, rj_wr_en, coeff_wr_en, data_wr_en;
  logic       mem_clear, data_clear, alu_en, out_mask;
  logic [4:0] rj_addr;
  logic [9:0] coeff_addr;
  logic [0:0] data_ch;
  logic [1:0] ch_idle;

  control_mc #(.NUM_CH(NCH), .RJ_DEPTH(16), .COEFF_DEPTH(512), .ZERO_RUN(ZR)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .soft_clear(soft_clear),
    .frame(frame), .in_valid(in_valid), .in_zero(in_zero), .in_ready(in_ready),
    .rj_wr_en(rj_wr_en), .rj_addr(rj_addr), .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr),
    .data_wr_en(data_wr_en), .data_ch(data_ch), .mem_clear(mem_clear), .data_clear(data_clear),
    .alu_en(alu_en), .out_mask(out_mask), .ch_idle(ch_idle)
  );

  wire [25:0] all_out = {in_ready, rj_wr_en, coeff_wr_en, data_wr_en, mem_clear, data_clear,
                         alu_en, out_mask, ch_idle, rj_addr, coeff_addr, data_ch};

  int n_chk = 0;
  int n_pass = 0;
  int n_rj = 0;
  int n_cf = 0;
  int sb[$];
  int zc[NCH];
  int mch = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int enc(input int kind, input int addr);
    return kind * 65536 + addr;
  endfunction

  function automatic int idle_model();
    int r = 0;
    for (int c = 0; c < NCH; c++) if (zc[c] == ZR) r |= (1 << c);
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    int ob;
    if (reset_n) begin
      ob = -1;
      if (rj_wr_en)    begin ob = enc(1, int'(rj_addr));    n_rj++; end
      if (coeff_wr_en) begin ob = enc(2, int'(coeff_addr)); n_cf++; end
      if (data_wr_en)  ob = enc(3, int'(data_ch));
      if (ob != -1) begin
        if (sb.size() == 0) chk("unexpected_write", ob, -1);
        else                chk("write", ob, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    n_rj = 0;
    n_cf = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 37 == 5) begin
        in_valid = 1'b0; frame = 1'b0;
        tick();
      end
      in_valid = 1'b1; in_zero = 1'b0;
      frame    = (i == 0 || i == NRJ);
      sb.push_back(i < NRJ ? enc(1, i) : enc(2, i - NRJ));
      tick();
    end
    in_valid = 1'b0; frame = 1'b0;
  endtask

  task automatic send(input bit f, input bit z, input bit exp_alu, input bit exp_mask);
    frame = f; in_valid = 1'b1; in_zero = z;
    if (f) mch = 0;
    sb.push_back(enc(3, mch));
    @(negedge clk);
    chk("alu_en", int'(alu_en), int'(exp_alu));
    chk("out_mask", int'(out_mask), int'(exp_mask));
    chk("ch_idle", int'(ch_idle), idle_model());
    if (z) zc[mch] = (zc[mch] == ZR) ? ZR : zc[mch] + 1;
    else   zc[mch] = 0;
    mch = (mch + 1) % NCH;
    tick();
    in_valid = 1'b0; frame = 1'b0; in_zero = 1'b0;
  endtask

  task automatic reset_model();
    mch = 0;
    for (int c = 0; c < NCH; c++) zc[c] = 0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; soft_clear = 1'b0;
    frame = 1'b0; in_valid = 1'b0; in_zero = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(all_out), 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("init_mem_clear", int'(mem_clear), 1);
    chk("init_data_clear", int'(data_clear), 1);
    chk("init_in_ready", int'(in_ready), 0);
    tick();

    // WAIT_RJ ignores a word without frame.
    in_valid = 1'b1;
    @(negedge clk);
    chk("wait_rj_ready", int'(in_ready), 1);
    chk("wait_rj_mem_clear", int'(mem_clear), 0);
    chk("wait_rj_noframe", int'(rj_wr_en), 0);
    tick();
    in_valid = 1'b0;

    load(NRJ + NCF);
    chk("rj_count", n_rj, NRJ);
    chk("coeff_count", n_cf, NCF);

    in_valid = 1'b1;
    @(negedge clk);
    chk("wait_data_noframe", int'(data_wr_en), 0);
    chk("wait_data_alu", int'(alu_en), 0);
    chk("wait_data_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;

    // Interleaved data, with an extra frame where channel 1 would have come next.
    send(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++)
      send((i < 5 && i % 2 == 0) || i == 5 || (i > 5 && i % 2 == 1), 1'b0, 1'b1, 1'b0);

    // Zero run: channel 0 saturates one sample before channel 1.
    for (int i = 0; i < 8; i++) send(i == 0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("both_idle", int'(ch_idle), 3);
    tick();
    @(negedge clk);
    chk("sleep_mask", int'(out_mask), 1);
    chk("sleep_alu", int'(alu_en), 0);
    tick();

    // Wake on a nonzero channel-1 sample.
    send(1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("wake_alu", int'(alu_en), 1);
    chk("wake_mask", int'(out_mask), 0);
    chk("wake_idle", int'(ch_idle), idle_model());
    tick();

    // Soft clear with a coincident sample, then a sample dropped during CLEARING.
    soft_clear = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("sc_cycle_data_clear", int'(data_clear), 0);
    chk("sc_cycle_no_write", int'(data_wr_en), 0);
    tick();
    soft_clear = 1'b0; frame = 1'b1;
    @(negedge clk);
    chk("clearing_data_clear", int'(data_clear), 1);
    chk("clearing_ready", int'(in_ready), 0);
    chk("clearing_mem_clear", int'(mem_clear), 0);
    tick();
    in_valid = 1'b0; frame = 1'b0;
    reset_model();
    @(negedge clk);
    chk("post_clear_ready", int'(in_ready), 1);
    chk("post_clear_data_clear", int'(data_clear), 0);
    chk("post_clear_idle", int'(ch_idle), 0);
    tick();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1, 1'b0);

    // Restart from WORKING, then again from the middle of the coefficient load.
    start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("start_outputs", int'(all_out), 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart_mem_clear", int'(mem_clear), 1);
    tick();
    load(NRJ + 8);
    start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("start_coeff_outputs", int'(all_out), 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart2_mem_clear", int'(mem_clear), 1);
    tick();
    load(NRJ + NCF);
    chk("reload_rj_count", n_rj, NRJ);
    chk("reload_coeff_count", n_cf, NCF);
    reset_model();

    for (int i = 0; i < 8; i++) send(i == 0, 1'b1, i != 0, 1'b0);
    tick();
    @(negedge clk);
    chk("sleep2_mask", int'(out_mask), 1);
    tick();

    // Asynchronous reset while sleeping.
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(all_out), 0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset2_mem_clear", int'(mem_clear), 1);
    tick();
    load(NRJ);
    chk("post_reset_rj_count", n_rj, NRJ);
    tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_mc.md
# control_mc

Parametrised multi-channel sequencing controller for the MSDAP datapath. It replaces the fixed two-channel control FSM. Load counters for Rj and coefficient words live inside the block, so it generates write strobes and addresses directly. It runs per-channel zero-run detection with a configurable sleep threshold, and supports synchronous restart and soft clear. It sits between the serial-to-parallel input stage and the Rj, coefficient and data memories plus the ALU.

## Interface
- NUM_CH, 2: number of interleaved audio channels (≥1)
- RJ_DEPTH, 16: Rj words per channel
- COEFF_DEPTH, 512: coefficient words per channel
- ZERO_RUN, 800: consecutive zero samples per channel before that channel counts as idle (≥1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  synchronous restart pulse; highest priority after reset
- soft_clear  in  1  synchronous data flush request, active-high
- frame  in  1  marks the first word of a block (load phases) or the channel-0 sample (data phase)
- in_valid  in  1  one parallel word available this cycle
- in_zero  in  1  current word equals zero (meaningful with in_valid)
- in_ready  out  1  controller accepts words
- rj_wr_en  out  1  Rj memory write strobe
- rj_addr  out  clog2(NUM_CH*RJ_DEPTH)  Rj write address
- coeff_wr_en  out  1  coefficient memory write strobe
- coeff_addr  out  clog2(NUM_CH*COEFF_DEPTH)  coefficient write address
- data_wr_en  out  1  data memory write strobe
- data_ch  out  clog2(NUM_CH) (min 1)  channel of current sample
- mem_clear  out  1  clear all memories
- data_clear  out  1  clear data memory and ALU accumulators
- alu_en  out  1  ALU/P2S enable
- out_mask  out  1  force zero output while sleeping
- ch_idle  out  NUM_CH  per-channel zero-run saturated

## Operation
- States: INIT, WAIT_RJ, READ_RJ, WAIT_COEFF, READ_COEFF, WAIT_DATA, WORKING, SLEEPING, CLEARING.
- INIT: mem_clear=1, data_clear=1. Counters, addresses, ch_idx and zero-run counters are zeroed. Always goes to WAIT_RJ next cycle.
- in_ready=1 in every state except INIT and CLEARING.
- WAIT_RJ: frame&&in_valid writes word at rj_addr=0 (rj_wr_en=1) and goes to READ_RJ.
- READ_RJ: rj_wr_en=in_valid; rj_addr increments after each write. The write at address NUM_CH*RJ_DEPTH-1 goes to WAIT_COEFF and clears the address.
- WAIT_COEFF and READ_COEFF: identical flow with coeff_wr_en, coeff_addr and NUM_CH*COEFF_DEPTH. The last write goes to WAIT_DATA.
- WAIT_DATA: frame&&in_valid writes the sample as channel 0 and goes to WORKING.
- WORKING and SLEEPING: data_wr_en=in_valid and data_ch=ch_idx.
  - ch_idx advances mod NUM_CH per accepted sample.
  - frame&&in_valid forces the current sample to channel 0; ch_idx becomes 1 (or 0 if NUM_CH=1).
- WORKING: alu_en=1.
- SLEEPING: alu_en=0, out_mask=1.
- Zero-run counter per channel:
  - on an accepted sample with in_zero, the counter for data_ch increments and saturates at ZERO_RUN;
  - on an accepted sample with !in_zero, it clears;
  - ch_idle[c] = (count[c]==ZERO_RUN).
- WORKING goes to SLEEPING on the cycle after all ch_idle bits are 1.
- SLEEPING goes to WORKING on the cycle after any accepted nonzero sample. The nonzero sample is still written.
- soft_clear in WAIT_DATA, WORKING or SLEEPING goes to CLEARING. It is ignored in the load states.
- CLEARING lasts one cycle:
  - data_clear=1 and in_ready=0;
  - zero-run counters and ch_idx are zeroed;
  - Rj and coefficient contents are untouched;
  - then goes to WAIT_DATA.
- Priority: reset_n > start > soft_clear > frame/data > sleep/wake.
- start from any state goes to INIT next cycle and outputs are 0 that cycle.

## Timing
- reset_n low forces state INIT and all registers to 0 asynchronously. During reset every output is 0, including in_ready, mem_clear and data_clear.
- After reset_n rises, the first clock edge executes INIT, so mem_clear is high for one cycle, then WAIT_RJ.
- Write strobes are combinational from state and in_valid, in the same cycle as the word. Address and data_ch are registered and valid in that same cycle. Increments take effect the next cycle.
- Load and data phases add zero latency.
- Sleep entry takes 1 cycle after the saturating zero sample. Wake takes 1 cycle after the nonzero sample.
- A sample arriving with soft_clear is not written.
- in_valid during CLEARING or INIT is dropped, since in_ready=0.
- frame without in_valid has no effect.
- Address wrap never occurs: the phase ends on the last address.

## Test plan
- Reset then load, NUM_CH=2, RJ_DEPTH=16, COEFF_DEPTH=512 -> mem_clear one cycle; rj_addr 0..31 and coeff_addr 0..1023 written once each; state WAIT_DATA after word 1056.
- Interleaved data with frame every 2 words, one mid-stream frame injected after an odd word count -> data_ch realigns to 0 on frame; alu_en high throughout.
- ZERO_RUN=4, both channels zero for 8 samples -> ch_idle=2'b11 after sample 8, SLEEPING next cycle, out_mask=1; channel 0 reaching 4 alone does not sleep.
- While sleeping, a single nonzero sample on channel 1 -> written with data_wr_en; WORKING next cycle; ch_idle[1]=0.
- soft_clear during WORKING coincident with in_valid -> no data write; data_clear one cycle; WAIT_DATA; Rj and coefficient addresses not rewritten.
- start during READ_COEFF, and reset_n low during SLEEPING -> INIT / all outputs 0; reload from rj_addr 0 succeeds.
